// File: rtl/aes_dsp_round_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_dsp_round_sched_if
// Description : Block-issue and datapath-control bundle for the AES round
//               scheduler (scheduler is the slave, block source the master).
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_dsp_round_sched_if #(
  parameter int SLOTS = 8,
  parameter int TAGW  = 4
);
  localparam int c_OCCW = $clog2(SLOTS + 1);

  logic              IN_VALID;
  logic [1:0]        IN_MODE;
  logic [TAGW-1:0]   IN_TAG;
  logic              IN_READY;
  logic              PTX_SEL;
  logic [3:0]        RND_IDX;
  logic              LAST_RND;
  logic              OUT_VALID;
  logic [TAGW-1:0]   OUT_TAG;
  logic [c_OCCW-1:0] OCC;

  modport master (
    output IN_VALID, IN_MODE, IN_TAG,
    input  IN_READY, PTX_SEL, RND_IDX, LAST_RND, OUT_VALID, OUT_TAG, OCC
  );

  modport slave (
    input  IN_VALID, IN_MODE, IN_TAG,
    output IN_READY, PTX_SEL, RND_IDX, LAST_RND, OUT_VALID, OUT_TAG, OCC
  );
endinterface
`default_nettype wire

// File: rtl/aes_dsp_round_sched.sv
`default_nettype none
// ============================================================================
// Module      : aes_dsp_round_sched
// Description : Per-slot issue/retire round scheduler for an interleaved
//               SLOTS-deep iterative AES round ring.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_dsp_round_sched #(
  parameter int SLOTS = 8,
  parameter int TAGW  = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  CLR,
  aes_dsp_round_sched_if.slave  bus
);

  localparam int                c_PTRW     = $clog2(SLOTS);
  localparam int                c_OCCW     = $clog2(SLOTS + 1);
  localparam logic [c_PTRW-1:0] c_PTR_LAST = c_PTRW'(SLOTS - 1);
  localparam logic [c_OCCW-1:0] c_OCC_ONE  = c_OCCW'(1);

  logic [c_PTRW-1:0] r_ptr;
  logic [SLOTS-1:0]  r_busy;
  logic [3:0]        r_k   [SLOTS];
  logic [3:0]        r_nr  [SLOTS];
  logic [TAGW-1:0]   r_tag [SLOTS];
  logic [c_OCCW-1:0] r_occ;

  logic              r_ptx_sel;
  logic [3:0]        r_rnd_idx;
  logic              r_last_rnd;
  logic              r_out_valid;
  logic [TAGW-1:0]   r_out_tag;

  logic              w_busy;
  logic [3:0]        w_k;
  logic [3:0]        w_nr;
  logic              w_retire;
  logic              w_issue;
  logic              w_ready;
  logic              w_accept;
  logic [3:0]        w_nr_new;

  // State of the slot currently sitting at the datapath input.
  assign w_busy   = r_busy[r_ptr];
  assign w_k      = r_k[r_ptr];
  assign w_nr     = r_nr[r_ptr];
  assign w_retire = w_busy & (w_k == w_nr);
  assign w_issue  = w_busy & (w_k < w_nr);
  assign w_ready  = ~CLR & (~w_busy | w_retire);
  assign w_accept = bus.IN_VALID & w_ready;

  always_comb begin
    w_nr_new = 4'd10;
    case (bus.IN_MODE)
      2'd1:    w_nr_new = 4'd12;
      2'd2:    w_nr_new = 4'd14;
      default: w_nr_new = 4'd10;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ptr       <= '0;
      r_busy      <= '0;
      r_occ       <= '0;
      r_ptx_sel   <= 1'b0;
      r_rnd_idx   <= 4'd0;
      r_last_rnd  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_tag   <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        r_k[i]   <= 4'd0;
        r_nr[i]  <= 4'd0;
        r_tag[i] <= '0;
      end
    end else if (CLR) begin
      // A block due to retire on this edge is dropped as well.
      r_ptr       <= '0;
      r_busy      <= '0;
      r_occ       <= '0;
      r_ptx_sel   <= 1'b0;
      r_rnd_idx   <= 4'd0;
      r_last_rnd  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_tag   <= '0;
    end else begin
      r_ptr       <= (r_ptr == c_PTR_LAST) ? '0 : r_ptr + c_PTRW'(1);
      r_ptx_sel   <= 1'b0;
      r_rnd_idx   <= 4'd0;
      r_last_rnd  <= 1'b0;
      r_out_valid <= w_retire;
      r_out_tag   <= w_retire ? r_tag[r_ptr] : '0;

      if (w_retire) begin
        r_busy[r_ptr] <= 1'b0;
      end

      if (w_accept) begin
        r_busy[r_ptr] <= 1'b1;
        r_k[r_ptr]    <= 4'd1;
        r_nr[r_ptr]   <= w_nr_new;
        r_tag[r_ptr]  <= bus.IN_TAG;
        r_ptx_sel     <= 1'b1;
      end else if (w_issue) begin
        r_rnd_idx     <= w_k;
        r_last_rnd    <= (w_k == (w_nr - 4'd1));
        r_k[r_ptr]    <= w_k + 4'd1;
      end

      // Accept and retire on one visit leave the count unchanged.
      if (w_accept && !w_retire) begin
        r_occ <= r_occ + c_OCC_ONE;
      end else if (w_retire && !w_accept) begin
        r_occ <= r_occ - c_OCC_ONE;
      end
    end
  end

  assign bus.IN_READY  = w_ready;
  assign bus.PTX_SEL   = r_ptx_sel;
  assign bus.RND_IDX   = r_rnd_idx;
  assign bus.LAST_RND  = r_last_rnd;
  assign bus.OUT_VALID = r_out_valid;
  assign bus.OUT_TAG   = r_out_tag;
  assign bus.OCC       = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_aes_dsp_round_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_dsp_round_sched
// Description : Scoreboard bench for aes_dsp_round_sched (SLOTS=8, TAGW=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_dsp_round_sched;

  localparam int S    = 8;
  localparam int TAGW = 4;

  typedef struct {
    int              t;
    int              nr;
    logic [TAGW-1:0] tag;
  } blk_t;

  logic CLK;
  logic RST_N;
  logic CLR;
  int   cyc;
  int   n_tests;
  int   n_fail;
  bit   mon_en;
  blk_t blk_q[$];

  aes_dsp_round_sched_if #(.SLOTS(S), .TAGW(TAGW)) bus ();

  aes_dsp_round_sched #(.SLOTS(S), .TAGW(TAGW)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CLR   (CLR),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic int nr_of(input logic [1:0] mode);
    case (mode)
      2'd1:    return 12;
      2'd2:    return 14;
      default: return 10;
    endcase
  endfunction

  // Monitor: expected outputs of each cycle follow from the accept time of
  // every live block (round j at t+1+j*S, result at t+1+NR*S).
  always @(negedge CLK) begin
    if (mon_en) begin
      logic            e_ptx, e_last, e_ov;
      logic [3:0]      e_rnd;
      logic [TAGW-1:0] e_tag, g_tag;
      int              e_occ;
      e_ptx = 1'b0; e_last = 1'b0; e_ov = 1'b0; e_rnd = 4'd0; e_tag = '0; e_occ = 0;
      for (int i = blk_q.size() - 1; i >= 0; i--) begin
        int d;
        int j;
        d = cyc - blk_q[i].t - 1;
        if (d >= 0 && d < blk_q[i].nr * S) e_occ++;
        if (d >= 0 && (d % S) == 0) begin
          j = d / S;
          if (j == 0) begin
            e_ptx = 1'b1;
          end else if (j < blk_q[i].nr) begin
            e_rnd  = 4'(j);
            e_last = (j == blk_q[i].nr - 1);
          end else if (j == blk_q[i].nr) begin
            e_ov  = 1'b1;
            e_tag = blk_q[i].tag;
            blk_q.delete(i);
          end
        end
      end
      g_tag = bus.OUT_VALID ? bus.OUT_TAG : '0;
      n_tests++;
      if ({bus.PTX_SEL, bus.RND_IDX, bus.LAST_RND, bus.OUT_VALID, g_tag} !==
          {e_ptx, e_rnd, e_last, e_ov, e_tag}) begin
        n_fail++;
        $display("FAIL ctl cyc=%0d got ptx=%b rnd=%0d last=%b ov=%b tag=%h exp ptx=%b rnd=%0d last=%b ov=%b tag=%h",
                 cyc, bus.PTX_SEL, bus.RND_IDX, bus.LAST_RND, bus.OUT_VALID, g_tag,
                 e_ptx, e_rnd, e_last, e_ov, e_tag);
      end
      n_tests++;
      if (int'(bus.OCC) != e_occ || $isunknown(bus.OCC)) begin
        n_fail++;
        $display("FAIL occ cyc=%0d got %0d exp %0d", cyc, bus.OCC, e_occ);
      end
    end
  end

  // One input cycle: drive, check IN_READY against slot occupancy, record accept.
  task automatic step(input logic v, input logic [1:0] mode, input logic [TAGW-1:0] tag,
                      input logic clr);
    logic exp_rdy;
    int   c;
    @(negedge CLK);
    #1;
    c            = cyc;
    bus.IN_VALID = v;
    bus.IN_MODE  = mode;
    bus.IN_TAG   = tag;
    CLR          = clr;
    exp_rdy      = !clr;
    foreach (blk_q[i]) begin
      if (((c - blk_q[i].t) % S) == 0 && (c - blk_q[i].t) < blk_q[i].nr * S) exp_rdy = 1'b0;
    end
    #1;
    n_tests++;
    if (bus.IN_READY !== exp_rdy) begin
      n_fail++;
      $display("FAIL in_ready cyc=%0d got %b exp %b", c, bus.IN_READY, exp_rdy);
    end
    if (clr) blk_q.delete();
    else if (v && exp_rdy) blk_q.push_back('{c, nr_of(mode), tag});
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 2'd0, '0, 1'b0);
  endtask

  task automatic chk_zero(input string name);
    n_tests++;
    if ({bus.PTX_SEL, bus.RND_IDX, bus.LAST_RND, bus.OUT_VALID, bus.OUT_TAG, bus.OCC} !== '0) begin
      n_fail++;
      $display("FAIL %s got ptx=%b rnd=%0d last=%b ov=%b tag=%h occ=%0d exp all 0", name,
               bus.PTX_SEL, bus.RND_IDX, bus.LAST_RND, bus.OUT_VALID, bus.OUT_TAG, bus.OCC);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    mon_en  = 1'b0;
    RST_N   = 1'b1;
    CLR     = 1'b0;
    bus.IN_VALID = 1'b0;
    bus.IN_MODE  = 2'd0;
    bus.IN_TAG   = '0;
    #1 RST_N = 1'b0;
    #1 chk_zero("reset_state");
    mon_en = 1'b1;
    repeat (3) @(posedge CLK);
    #2 RST_N = 1'b1;

    // Single AES-128 block
    step(1'b1, 2'd0, 4'h5, 1'b0);
    idle(85);

    // Full ring of AES-128, then retire+accept on the same visit
    for (int i = 0; i < S; i++) step(1'b1, 2'd0, 4'(i), 1'b0);
    idle(72);
    step(1'b1, 2'd0, 4'h9, 1'b0);
    idle(100);

    // Mixed modes: AES-256 then AES-128
    step(1'b1, 2'd2, 4'hA, 1'b0);
    step(1'b1, 2'd0, 4'hB, 1'b0);
    idle(120);

    // Reserved mode behaves as AES-128
    step(1'b1, 2'd3, 4'hC, 1'b0);
    idle(85);

    // Synchronous clear with 4 blocks in flight at cycle 40
    for (int i = 1; i <= 4; i++) step(1'b1, 2'd0, 4'(i), 1'b0);
    idle(36);
    step(1'b0, 2'd0, '0, 1'b1);
    idle(90);
    step(1'b1, 2'd1, 4'hD, 1'b0);
    idle(105);

    // Asynchronous reset mid-cycle with a full ring
    for (int i = 0; i < S; i++) step(1'b1, 2'd0, 4'(8 + i), 1'b0);
    idle(20);
    @(posedge CLK);
    #2 RST_N = 1'b0;
    blk_q.delete();
    #1 chk_zero("async_reset");
    @(posedge CLK);
    #2 RST_N = 1'b1;
    #1;
    n_tests++;
    if (bus.IN_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset got %b exp 1", bus.IN_READY);
    end
    idle(90);

    mon_en = 1'b0;
    n_tests++;
    if (blk_q.size() != 0) begin
      n_fail++;
      $display("FAIL drained got %0d pending blocks exp 0", blk_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got no end of stimulus exp finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
